// File: rtl/pack4x10to40.sv
// Packs LANES narrow lane words into one wide word over valid/ready streams.
// Define PACK4X10_LAST_EN to add in_last/out_keep for short closing words.
module pack4x10to40 #(
    parameter int LANE_W = 10,
    parameter int LANES  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANE_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
`ifdef PACK4X10_LAST_EN
    input  logic                    in_last,
`endif
    output logic [LANE_W*LANES-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef PACK4X10_LAST_EN
    ,
    output logic [LANES-1:0]        out_keep
`endif
);

    localparam int CW = $clog2(LANES);
    localparam int OW = LANE_W * LANES;
    localparam int AW = LANE_W * (LANES - 1);

    logic [CW-1:0] cnt;
    logic [AW-1:0] acc;
    logic [OW-1:0] acc_ext;
    logic [OW-1:0] word;
    logic          closing;
    logic          fire;
`ifdef PACK4X10_LAST_EN
    logic [LANES-1:0] keep;
`endif

    always_comb begin
        closing = (cnt == CW'(LANES - 1));
`ifdef PACK4X10_LAST_EN
        if (in_last) closing = 1'b1;
`endif
    end

    // Only the closing lane can stall; earlier lanes land in acc.
    assign in_ready = !closing || !out_valid || out_ready;
    assign fire     = in_valid && in_ready;
    assign acc_ext  = {{LANE_W{1'b0}}, acc};

    // Lanes past the closing one are forced to zero for short words.
    always_comb begin
        word = '0;
`ifdef PACK4X10_LAST_EN
        keep = '0;
`endif
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(cnt))
                word[k*LANE_W +: LANE_W] = acc_ext[k*LANE_W +: LANE_W];
            else if (k == int'(cnt))
                word[k*LANE_W +: LANE_W] = in_data;
`ifdef PACK4X10_LAST_EN
            keep[k] = (k <= int'(cnt));
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef PACK4X10_LAST_EN
            out_keep  <= '0;
`endif
        end else if (fire && closing) begin
            out_data  <= word;
            out_valid <= 1'b1;
            cnt       <= '0;
`ifdef PACK4X10_LAST_EN
            out_keep  <= keep;
`endif
        end else begin
            if (out_ready) out_valid <= 1'b0;
            if (fire) begin
                for (int k = 0; k < LANES - 1; k++) begin
                    if (cnt == CW'(k))
                        acc[k*LANE_W +: LANE_W] <= in_data;
                end
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pack4x10to40.sv
// Bench for pack4x10to40: cycle table for handshake timing plus
// a lane-model scoreboard checking every transferred output word.
module tb_pack4x10to40;

    localparam int LW = 10;
    localparam int LN = 4;
    localparam int W  = LW * LN;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [LW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
`ifdef PACK4X10_LAST_EN
    logic          in_last;
    logic [LN-1:0] out_keep;
`endif

    always #5 clk = ~clk;

    pack4x10to40 #(.LANE_W(LW), .LANES(LN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef PACK4X10_LAST_EN
        .in_last   (in_last),
        .out_keep  (out_keep),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0]  d;
        logic [LN-1:0] k;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic [LW-1:0] mlane[LN];
    int            mcnt = 0;
    logic          mclose;
    exp_t          mw;

    // Independent lane model: accepts seen at negedge build expected words.
    always @(negedge clk) begin
        if (!rst_n) begin
            mcnt = 0;
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: got word %h, none expected",
                             out_data);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", 64'(out_data), 64'(e.d));
`ifdef PACK4X10_LAST_EN
                    chk("sb_keep", 64'(out_keep), 64'(e.k));
`endif
                end
            end
            if (in_valid && in_ready) begin
                mlane[mcnt] = in_data;
                mclose = (mcnt == LN - 1);
`ifdef PACK4X10_LAST_EN
                if (in_last) mclose = 1'b1;
`endif
                if (mclose) begin
                    mw = '0;
                    for (int k = 0; k <= mcnt; k++) begin
                        mw.d[k*LW +: LW] = mlane[k];
                        mw.k[k] = 1'b1;
                    end
                    sb.push_back(mw);
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
            end
        end
    end

    typedef struct {
        logic [LW-1:0] d;
        logic          v;
        logic          ordy;
        logic          erdy;
        logic          eov;
        logic [W-1:0]  eod;
    } vec_t;

    vec_t tbl[19];

    task automatic drive(input logic [LW-1:0] d, input logic v,
                         input logic ordy, input logic last);
        @(posedge clk);
        #1;
        in_data   = d;
        in_valid  = v;
        out_ready = ordy;
`ifdef PACK4X10_LAST_EN
        in_last   = last;
`endif
    endtask

    initial begin
        logic [W-1:0] w1234, w_a, w_b;
        w1234 = {10'h004, 10'h003, 10'h002, 10'h001};
        w_a   = {10'h2AA, 10'h155, 10'h000, 10'h3FF};
        w_b   = {10'h040, 10'h030, 10'h020, 10'h010};

        tbl[0]  = '{10'h001, 1, 1, 1, 0, '0};
        tbl[1]  = '{10'h002, 1, 1, 1, 0, '0};
        tbl[2]  = '{10'h003, 1, 1, 1, 0, '0};
        tbl[3]  = '{10'h004, 1, 1, 1, 0, '0};
        tbl[4]  = '{10'h3FF, 1, 1, 1, 1, w1234};
        tbl[5]  = '{10'h000, 1, 1, 1, 0, '0};
        tbl[6]  = '{10'h155, 1, 1, 1, 0, '0};
        tbl[7]  = '{10'h2AA, 1, 1, 1, 0, '0};
        tbl[8]  = '{10'h001, 1, 1, 1, 1, w_a};
        tbl[9]  = '{10'h002, 1, 1, 1, 0, '0};
        tbl[10] = '{10'h003, 1, 1, 1, 0, '0};
        tbl[11] = '{10'h004, 1, 1, 1, 0, '0};
        tbl[12] = '{10'h010, 1, 0, 1, 1, w1234};
        tbl[13] = '{10'h020, 1, 0, 1, 1, w1234};
        tbl[14] = '{10'h030, 1, 0, 1, 1, w1234};
        tbl[15] = '{10'h040, 1, 0, 0, 1, w1234};
        tbl[16] = '{10'h040, 1, 1, 1, 1, w1234};
        tbl[17] = '{10'h000, 0, 1, 1, 1, w_b};
        tbl[18] = '{10'h000, 0, 1, 1, 0, '0};

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef PACK4X10_LAST_EN
        in_last   = 1'b0;
`endif
        #12;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].d, tbl[i].v, tbl[i].ordy, 1'b0);
            @(negedge clk);
            chk($sformatf("in_ready[%0d]", i), 64'(in_ready),
                64'(tbl[i].erdy));
            chk($sformatf("out_valid[%0d]", i), 64'(out_valid),
                64'(tbl[i].eov));
            if (tbl[i].eov)
                chk($sformatf("out_data[%0d]", i), 64'(out_data),
                    64'(tbl[i].eod));
        end

        // Reset mid-word: partial word discarded, held output cleared.
        drive(10'h0A1, 1, 1, 0);
        drive(10'h0A2, 1, 1, 0);
        drive(10'h000, 0, 1, 0);
        @(negedge clk);
        out_ready = 1'b0;
        drive(10'h000, 0, 0, 0);
        drive(10'h0A3, 1, 0, 0);
        drive(10'h0A4, 1, 0, 0);
        drive(10'h0A5, 1, 0, 0);
        @(negedge clk);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b0;
        drive(10'h011, 1, 1, 0);
        drive(10'h012, 1, 1, 0);
        drive(10'h013, 1, 1, 0);
        drive(10'h014, 1, 1, 0);
        drive(10'h000, 0, 1, 0);
        @(negedge clk);
        chk("post_rst_data", 64'(out_data),
            64'({10'h014, 10'h013, 10'h012, 10'h011}));

`ifdef PACK4X10_LAST_EN
        drive(10'h0AA, 1, 1, 0);
        drive(10'h0BB, 1, 1, 1);
        drive(10'h000, 0, 1, 0);
        @(negedge clk);
        chk("last2_data", 64'(out_data), 64'({20'h0, 10'h0BB, 10'h0AA}));
        chk("last2_keep", 64'(out_keep), 64'(4'b0011));
        drive(10'h001, 1, 1, 0);
        drive(10'h002, 1, 1, 0);
        drive(10'h003, 1, 1, 0);
        drive(10'h004, 1, 1, 1);
        drive(10'h000, 0, 1, 0);
        @(negedge clk);
        chk("last4_data", 64'(out_data), 64'(w1234));
        chk("last4_keep", 64'(out_keep), 64'(4'b1111));
`endif

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
